// File: rtl/checksum_encoder.sv
// Full-checksum matrix encoder: N data rows widened with a row-sum element, then one column-checksum row.
// Optional macro CHECKSUM_ENCODER_ROWSUM_EN enables the row-sum element and its column accumulator.
module checksum_encoder #(
  parameter int N = 32,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*W-1:0]       in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [(N+1)*W-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 encode_done
);

  localparam int CNT_W = $clog2(N+1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(N-1);

  typedef enum logic [1:0] {IDLE, ACCEPT, EMIT_CS, DONE} state_t;

  state_t                  state_q, state_d;
  logic [N:0][W-1:0]       col_acc_q, col_acc_d;
  logic [CNT_W-1:0]        row_cnt_q, row_cnt_d;
  logic [(N+1)*W-1:0]      out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    encode_done_q, encode_done_d;
  logic [W-1:0]            rowsum;
  logic                    out_free, in_fire, out_fire;

  // The single output slot is free when empty or being drained this cycle.
  assign out_free    = !out_valid_q | out_ready;
  assign in_ready    = (state_q == ACCEPT) & out_free;
  assign in_fire     = in_ready & in_valid;
  assign out_fire    = out_valid_q & out_ready;

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign busy        = (state_q != IDLE);
  assign encode_done = encode_done_q;

`ifdef CHECKSUM_ENCODER_ROWSUM_EN
  always_comb begin
    rowsum = '0;
    for (int j = 0; j < N; j++) rowsum = rowsum + in_data[W*j +: W];
  end
`else
  assign rowsum = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCEPT;
      ACCEPT:  if (in_fire && row_cnt_q == LAST_ROW) state_d = EMIT_CS;
      EMIT_CS: if (out_free) state_d = DONE;
      DONE:    if (out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    col_acc_d     = col_acc_q;
    row_cnt_d     = row_cnt_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q & ~out_ready;
    out_last_d    = out_last_q;
    encode_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          col_acc_d = '0;
          row_cnt_d = '0;
        end
      end
      ACCEPT: begin
        if (in_fire) begin
          out_data_d  = {rowsum, in_data};
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          for (int j = 0; j < N; j++) col_acc_d[j] = col_acc_q[j] + in_data[W*j +: W];
`ifdef CHECKSUM_ENCODER_ROWSUM_EN
          col_acc_d[N] = col_acc_q[N] + rowsum;
`endif
          row_cnt_d = row_cnt_q + 1'b1;
        end
      end
      EMIT_CS: begin
        // Loaded after the last row's update has landed in col_acc_q.
        if (out_free) begin
          out_data_d  = col_acc_q;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
        end
      end
      DONE: begin
        if (out_fire) encode_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_acc_q     <= '0;
      row_cnt_q     <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      encode_done_q <= 1'b0;
    end else begin
      col_acc_q     <= col_acc_d;
      row_cnt_q     <= row_cnt_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      encode_done_q <= encode_done_d;
    end
  end

endmodule

// File: tb/tb_checksum_encoder.sv
// Self-checking bench for checksum_encoder: directed and randomized matrices against a sum-based reference.
module tb_checksum_encoder;
  localparam int N = 32;
  localparam int W = 32;

  logic                clk = 1'b0;
  logic                rst, start, in_valid, out_ready;
  logic [N*W-1:0]      in_data;
  logic                in_ready;
  logic [(N+1)*W-1:0]  out_data;
  logic                out_valid, out_last, busy, encode_done;

  checksum_encoder #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .encode_done(encode_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [(N+1)*W-1:0] got_q[$];
  logic               got_last_q[$];
  int                 done_cnt = 0;
  int                 done_cyc = 0;
  bit                 rand_rdy = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_last_q.push_back(out_last);
    end
    if (encode_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  always @(posedge clk) if (rand_rdy) begin #1; out_ready = 1'($urandom_range(0, 1)); end

  logic [W-1:0] mat [N][N];

  function automatic logic [N*W-1:0] pack_row(int r);
    logic [N*W-1:0] v;
    for (int j = 0; j < N; j++) v[W*j +: W] = mat[r][j];
    return v;
  endfunction

  function automatic logic [(N+1)*W-1:0] exp_row(int r);
    logic [(N+1)*W-1:0] v;
    longint s = 0;
    for (int j = 0; j < N; j++) begin
      v[W*j +: W] = mat[r][j];
      s += longint'(mat[r][j]);
    end
`ifdef CHECKSUM_ENCODER_ROWSUM_EN
    v[W*N +: W] = s[W-1:0];
`else
    v[W*N +: W] = '0;
`endif
    return v;
  endfunction

  function automatic logic [(N+1)*W-1:0] exp_cs();
    logic [(N+1)*W-1:0] v;
    longint total = 0;
    for (int j = 0; j < N; j++) begin
      longint c = 0;
      for (int r = 0; r < N; r++) c += longint'(mat[r][j]);
      v[W*j +: W] = c[W-1:0];
      total += c;
    end
`ifdef CHECKSUM_ENCODER_ROWSUM_EN
    v[W*N +: W] = total[W-1:0];
`else
    v[W*N +: W] = '0;
`endif
    return v;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_row(int r);
    bit ok = 0;
    in_data  = pack_row(r);
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_row %0d: in_ready=0 after 200 cycles, required 1", r);
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400; k++) begin
      if (done_cnt > 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic run_matrix(string name, bit bp, int stray_row, bit chk_lat);
    int c0;
    logic [(N+1)*W-1:0] e;
    got_q.delete();
    got_last_q.delete();
    done_cnt = 0;
    c0 = cyc;
    pulse_start();
    for (int r = 0; r < N; r++) begin
      if (r == stray_row) start = 1'b1;
      send_row(r);
      start = 1'b0;
      if (r == 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_row(0)) begin
          errors++;
          $display("FAIL %s latency: out_valid=%b data=%h, required 1 %h", name, out_valid, out_data, exp_row(0));
        end
      end
      if (r == 0 && bp) begin
        in_data  = pack_row(1);
        in_valid = 1'b1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== exp_row(0)) begin
            errors++;
            $display("FAIL %s stall: in_ready=%b out_valid=%b data=%h", name, in_ready, out_valid, out_data);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    end
    wait_done();
    checks++;
    if (got_q.size() != N + 1) begin
      errors++;
      $display("FAIL %s row_count: got %0d, required %0d", name, got_q.size(), N + 1);
    end
    for (int i = 0; i < got_q.size() && i <= N; i++) begin
      e = (i < N) ? exp_row(i) : exp_cs();
      checks++;
      if (got_q[i] !== e || got_last_q[i] !== (i == N)) begin
        errors++;
        $display("FAIL %s row%0d: got %h last=%b, required %h last=%b", name, i, got_q[i], got_last_q[i], e, (i == N));
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s encode_done: %0d pulses, required 1", name, done_cnt);
    end
    if (chk_lat) begin
      checks++;
      if (done_cyc - c0 != N + 3) begin
        errors++;
        $display("FAIL %s done_latency: %0d cycles, required %0d", name, done_cyc - c0, N + 3);
      end
    end
  endtask

  task automatic fill(logic [W-1:0] v);
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) mat[r][j] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    checks++;
    if (out_valid !== 0 || out_last !== 0 || out_data !== '0 || in_ready !== 0 || busy !== 0 || encode_done !== 0) begin
      errors++;
      $display("FAIL reset_state: ov=%b ol=%b od=%h ir=%b busy=%b done=%b, required all 0",
               out_valid, out_last, out_data, in_ready, busy, encode_done);
    end
    in_valid = 1'b1; in_data = '1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 0 || in_ready !== 0 || out_valid !== 0) begin
      errors++;
      $display("FAIL idle_ignore: busy=%b in_ready=%b out_valid=%b, required 0 0 0", busy, in_ready, out_valid);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_all_ones();
    logic [(N+1)*W-1:0] cs;
    logic [W-1:0] e32;
    fill(1);
    run_matrix("all_ones", 0, -1, 1);
`ifdef CHECKSUM_ENCODER_ROWSUM_EN
    e32 = 1024;
`else
    e32 = 0;
`endif
    if (got_q.size() == N + 1) begin
      cs = got_q[N];
      checks++;
      if (cs[W*N +: W] !== e32 || cs[0 +: W] !== 32) begin
        errors++;
        $display("FAIL all_ones cs_const: elem32=%0d elem0=%0d, required %0d 32", cs[W*N +: W], cs[0 +: W], e32);
      end
    end
  endtask

  task automatic test_wrap();
    fill(0);
    mat[0][0] = 32'hFFFF_FFFF;
    mat[1][0] = 32'h1;
    run_matrix("wrap", 0, -1, 1);
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) mat[r][j] = $urandom;
    run_matrix("backpressure", 1, -1, 0);
  endtask

  task automatic test_reset_mid();
    fill(7);
    pulse_start();
    for (int r = 0; r < 10; r++) send_row(r);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 0 || busy !== 0 || in_ready !== 0) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b busy=%b in_ready=%b, required 0 0 0", out_valid, busy, in_ready);
    end
    fill(1);
    run_matrix("after_reset", 0, -1, 1);
  endtask

  task automatic test_stray_start();
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) mat[r][j] = $urandom_range(0, 1000);
    run_matrix("stray_start", 0, 5, 1);
  endtask

  task automatic test_random();
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) mat[r][j] = $urandom;
    run_matrix("random_full", 0, -1, 1);
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) mat[r][j] = $urandom;
    rand_rdy = 1;
    run_matrix("random_ready", 0, -1, 0);
    rand_rdy = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_stray_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/checksum_encoder.md
# checksum_encoder

Generates the full-checksum-encoded matrix that the downstream checksum verifier consumes. The block accepts N data rows of W-bit elements and emits each one widened to N+1 elements, with the row sum appended as the last element. After the N data rows it emits one more row, the column-checksum row, holding the column sums. It sits between the operand/result buffers and the fault-tolerance path, and produces rows in the same (N+1)·W packing that the verifier expects.

## Interface
- N, 32, elements per data row and number of data rows
- W, 32, element width; all sums are modulo 2^W
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a new matrix; only accepted in IDLE
- in_data  in  N·W  data row; element j at bits [W·j +: W]
- in_valid  in  1  in_data is valid
- in_ready  out  1  the block accepts a row this cycle
- out_data  out  (N+1)·W  encoded row; element j at bits [W·j +: W], element N is the checksum element
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream takes out_data this cycle
- out_last  out  1  marks the column-checksum row; qualified by out_valid
- busy  out  1  state is not IDLE
- encode_done  out  1  one-cycle pulse after the checksum row is transferred

## Operation
- **States:** IDLE, ACCEPT, EMIT_CS, DONE.
- **IDLE:**
  - start=1 clears col_acc[0..N] and row_cnt, then moves to ACCEPT.
  - in_ready=0.
- **ACCEPT:**
  - in_ready = !out_valid | out_ready.
  - On an input transfer:
    - rowsum = Σ in_data[j] mod 2^W.
    - The output register loads {rowsum, in_data}. out_valid=1, out_last=0.
    - col_acc[j] += in_data[j] for j<N, and col_acc[N] += rowsum.
    - row_cnt increments.
  - When row_cnt reaches N on a transfer, go to EMIT_CS.
- **EMIT_CS:**
  - in_ready=0.
  - When !out_valid | out_ready, the output register loads col_acc[0..N] (including the row N−1 contribution), out_valid=1, out_last=1, and the state moves to DONE.
- **DONE:**
  - in_ready=0.
  - On out_valid & out_ready: out_valid=0, encode_done=1 for one cycle, next state IDLE.
- **Output register:**
  - Single entry.
  - On out_valid & out_ready with no new load, out_valid clears.
  - out_data and out_last hold stable while out_valid & !out_ready.
- **Arithmetic:** all adds are W bits, and carries out are discarded. This wrap matches the verifier's comparison.
- **Boundary conditions:**
  - start outside IDLE is ignored.
  - in_valid outside ACCEPT is ignored.
  - start and rst in the same cycle: rst wins.
  - rst mid-matrix drops the partial matrix; the next start begins clean.

## Timing
- **Reset values:** out_valid=0, out_last=0, out_data=0, in_ready=0, busy=0, encode_done=0, state IDLE, col_acc=0, row_cnt=0.
- **Latency:** input transfer in cycle t gives out_valid with that row at t+1.
- **Throughput:** with out_ready held at 1, one row per cycle. The checksum row appears the cycle after the last data row is transferred, then encode_done follows.
- **Minimum matrix:** start → N+3 cycles to encode_done under full throughput.
- **Backpressure:** in_ready is combinational from out_valid/out_ready/state; there is no combinational path from in_valid to in_ready.
- **busy:** rises the cycle after an accepted start and falls with the return to IDLE.

## Configuration
- `CHECKSUM_ENCODER_ROWSUM_EN` defined:
  - Element N of every data row is the row sum.
  - col_acc[N] accumulates the row sums, giving full encoding.
- Undefined:
  - Element N of every data row is 0 and col_acc[N] stays 0, so the checksum row's element N is 0.
  - Only column encoding is produced, and the rowsum adder tree is not synthesized.

## Test plan
- **All-ones matrix:** start, then 32 rows with every element =1 and out_ready=1.
  - Each data row's element 32 = 32.
  - Checksum row: elements 0..31 = 32, element 32 = 1024, out_last=1.
  - encode_done pulses once.
- **Wrap:** row 0 element 0 = 0xFFFFFFFF, row 1 element 0 = 1, everything else 0.
  - Row 0 element 32 = 0xFFFFFFFF.
  - Checksum row: element 0 = 0, element 32 = 0.
- **Backpressure:** hold out_ready=0 for 5 cycles after the first row.
  - in_ready=0 throughout.
  - out_data stays stable.
  - No rows are lost, and the checksum row is still correct.
- **Reset mid-matrix:** assert rst after 10 rows.
  - Next cycle: out_valid=0, busy=0.
  - A new start with all-ones rows gives a checksum row of 32s.
- **Stray start:** start pulsed while in ACCEPT at row 5.
  - Ignored: row_cnt continues, and the checksum equals the no-pulse run.
- **Macro off:** rebuild without `CHECKSUM_ENCODER_ROWSUM_EN` and run the all-ones matrix.
  - Every element 32 is 0, including in the checksum row.
  - Checksum elements 0..31 are still 32.
